// File: rtl/alu_exec.sv
// Registered ALU execution unit: one-cycle and/or/add/sub/slt, iterative shift-add mul.
// Optional build macro ALU_EXEC_EARLY_TERM_EN ends a multiply once the shifted multiplier is zero.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_count;

  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_mplier_next;
  logic             w_slt;
  logic             w_last;

  assign w_slt = $signed(src_a) < $signed(src_b);

  always_comb begin
    // NOTE: default assignment first so every path drives w_alu_res and no latch is inferred.
    w_alu_res = '0;
    case (alu_control)
      OP_AND:  w_alu_res = src_a & src_b;
      OP_OR:   w_alu_res = src_a | src_b;
      OP_ADD:  w_alu_res = src_a + src_b;
      OP_SUB:  w_alu_res = src_a - src_b;
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
      default: w_alu_res = '0;
    endcase
  end

  assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_next = r_mplier >> 1;

`ifdef ALU_EXEC_EARLY_TERM_EN
  assign w_last = (r_count == LAST_ITER) || (w_mplier_next == '0);
`else
  assign w_last = (r_count == LAST_ITER);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (alu_control == OP_MUL) begin
`ifdef ALU_EXEC_EARLY_TERM_EN
              if (src_b == '0) begin
                r_result    <= '0;
                r_zero      <= 1'b1;
                r_out_valid <= 1'b1;
                r_state     <= S_DONE;
              end else
`endif
              begin
                r_mcand  <= src_a;
                r_mplier <= src_b;
                r_acc    <= '0;
                r_count  <= '0;
                r_state  <= S_MUL;
              end
            end else begin
              r_result    <= w_alu_res;
              r_zero      <= (w_alu_res == '0);
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_next;
          r_count  <= r_count + CW'(1);
          // Only the low WIDTH bits are kept; signed and unsigned products agree there.
          if (w_last) begin
            r_result    <= w_acc_next;
            r_zero      <= (w_acc_next == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_MUL);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: driver pushes model results, negedge monitor pops on output handshake.
module tb_alu_exec;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zro;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       alu_control = 3'b000;
  logic [WIDTH-1:0] src_a = '0;
  logic [WIDTH-1:0] src_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  alu_exec #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [2:0] code, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (code)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b100:  return a - b;
      3'b101:  return a * b;
      3'b110:  return (sa < sb) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // Edges between the accept edge and the first cycle showing out_valid.
  function automatic int exp_lat(input logic [2:0] code, input logic [WIDTH-1:0] b);
    int h;
    if (code != 3'b101) return 0;
`ifdef ALU_EXEC_EARLY_TERM_EN
    h = 0;
    for (int i = 0; i < WIDTH; i++) if (b[i]) h = i + 1;
    return h;
`else
    h = WIDTH;
    return h;
`endif
  endfunction

  task automatic send(input logic [2:0] code, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input int hold);
    logic [WIDTH-1:0] er;
    int t, lat, waited, busy_n;
    er  = model(code, a, b);
    lat = exp_lat(code, b);
    t = 0;
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    check("in_ready_before_issue", in_ready, 1);
    in_valid = 1'b1; alu_control = code; src_a = a; src_b = b;
    out_ready = (hold == 0);
    sb_q.push_back('{res: er, zro: (er == '0)});
    @(posedge clk); #1;
    in_valid = 1'b0; alu_control = 3'($urandom); src_a = $urandom; src_b = $urandom;
    waited = 0; busy_n = 0;
    while (!out_valid && waited < 200) begin
      if (busy) busy_n++;
      @(posedge clk); #1; waited++;
    end
    check("latency", waited, lat);
    check("busy_cycles", busy_n, lat);
    check("in_ready_in_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0]; alu_control = 3'b010;
      check("hold_valid", out_valid, 1);
      check("hold_result", result, er);
      check("hold_zero", zero, er == '0);
      check("hold_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (hold > 0) check("after_hold_result", result, er);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("out_valid_cleared", out_valid, 0);
    check("in_ready_idle", in_ready, 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("stale_output", out_valid, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_result", result, mon_e.res);
        check("sb_zero", zero, mon_e.zro);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] code;
    logic [WIDTH-1:0] a, b;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    send(3'b100, 32'd5, 32'd5, 0);
    send(3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    send(3'b101, 32'h0001_0003, 32'h0000_0007, 0);
    send(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10);
    send(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    send(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    // Abort a multiply partway through; nothing from it may surface.
    in_valid = 1'b1; alu_control = 3'b101; src_a = 32'h0000_1234; src_b = 32'h8000_0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_result", result, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
    send(3'b001, 32'hF0F0_0000, 32'h0000_0F0F, 0);

    send(3'b101, 32'd9, 32'd0, 0);
    send(3'b101, 32'd9, 32'd4, 0);
    send(3'b110, 32'h0000_0001, 32'h8000_0000, 0);
    send(3'b110, 32'h8000_0000, 32'h8000_0000, 0);

    for (int i = 0; i < 40; i++) begin
      code = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (i % 4 == 0) b = b >> $urandom_range(0, 31);
      if (i % 7 == 0) a = b;
      send(code, a, b, (i % 9 == 0) ? 3 : 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
